// File: rtl/clk_div_gen.sv
// Programmable 50%-duty clock/tick generator with glitch-free divisor reload
// and clean start/stop at period boundaries.
module clk_div_gen #(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_HALF = 500,
  parameter bit START_EN     = 1'b1
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic             qtick,
  output logic [1:0]       phase,
  output logic             running
);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

  localparam logic [DIV_W-1:0] RST_HALF = clamp_div(DIV_W'(DEFAULT_HALF));

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clk_q, clk_d;
  logic             run_q, run_d;
  logic             pmid_q, pmid_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             qtick_q, qtick_d;
  logic             boot_q, boot_d;

  logic [DIV_W-1:0] mid;
  logic             last;
  logic             apply;

  assign mid  = half_q >> 1;
  assign last = (cnt_q == half_q - DIV_W'(1));

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    clk_d   = clk_q;
    run_d   = run_q;
    pmid_d  = pmid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    qtick_d = 1'b0;
    boot_d  = 1'b0;
    apply   = 1'b0;

    if (run_q) begin
      // Running out of reset without en: drop out at once instead of finishing a half.
      if (boot_q && !en) begin
        run_d  = 1'b0;
        cnt_d  = '0;
        clk_d  = 1'b0;
        pmid_d = 1'b0;
      end else if (last) begin
        cnt_d  = '0;
        pmid_d = 1'b0;
        if (clk_q) begin
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          qtick_d = 1'b1;
        end else if (!en) begin
          run_d = 1'b0;
        end else begin
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          qtick_d = 1'b1;
          apply   = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
        if ((mid != '0) && (cnt_q == mid - DIV_W'(1))) begin
          qtick_d = 1'b1;
          pmid_d  = 1'b1;
        end
      end
    end else if (en) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      clk_d  = 1'b0;
      pmid_d = 1'b0;
      apply  = 1'b1;
    end

    if (apply && busy_q) begin
      half_d = pend_q;
      busy_d = 1'b0;
    end
    // A load on the apply cycle becomes the next pending value.
    if (div_load) begin
      pend_d = clamp_div(div_in);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cnt_q   <= '0;
      half_q  <= RST_HALF;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      clk_q   <= 1'b0;
      run_q   <= START_EN;
      pmid_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      qtick_q <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      clk_q   <= clk_d;
      run_q   <= run_d;
      pmid_q  <= pmid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      qtick_q <= qtick_d;
      boot_q  <= boot_d;
    end
  end

  assign div_busy = busy_q;
  assign clk_out  = clk_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign qtick    = qtick_q;
  assign phase    = {clk_q, pmid_q};
  assign running  = run_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: table of timed vectors plus hand sequences
// for reset, boot-without-enable and first-rise latency.
module tb_clk_div_gen;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        div_busy, clk_out, rise, fall, qtick, running;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_gen #(.DIV_W(16), .DEFAULT_HALF(500), .START_EN(1'b1)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .div_busy(div_busy),
    .clk_out (clk_out),
    .rise    (rise),
    .fall    (fall),
    .qtick   (qtick),
    .phase   (phase),
    .running (running)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int          n;
    logic        en;
    logic        dl;
    logic [15:0] din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[41];

  function automatic vec_t row(int n, bit e, bit dl, int din, bit c, bit r, bit f,
                               bit q, int ph, bit b, bit run);
    vec_t v;
    v.n   = n;
    v.en  = e;
    v.dl  = dl;
    v.din = 16'(din);
    v.exp = {c, r, f, q, 2'(ph), b, run};
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {clk_out, rise, fall, qtick, phase, div_busy, running};
  endfunction

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act[7:0], exp[7:0]);
    end
  endtask

  initial begin
    // n, en, dl, din | clk rise fall qtick phase busy run
    vecs[0]  = row(250, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[1]  = row(1,   1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[2]  = row(249, 1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[3]  = row(1,   1, 0, 0, 1, 0, 0, 0, 2, 0, 1);
    vecs[4]  = row(249, 1, 0, 0, 1, 0, 0, 1, 3, 0, 1);
    vecs[5]  = row(250, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[6]  = row(499, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[7]  = row(1,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[8]  = row(1,   1, 1, 3, 1, 0, 0, 0, 2, 1, 1);
    vecs[9]  = row(499, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    vecs[10] = row(500, 1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[11] = row(1,   1, 0, 0, 1, 0, 0, 1, 3, 0, 1);
    vecs[12] = row(2,   1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[13] = row(3,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[14] = row(6,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[15] = row(1,   1, 1, 7, 1, 0, 0, 1, 3, 1, 1);
    vecs[16] = row(1,   1, 1, 4, 1, 0, 0, 0, 3, 1, 1);
    vecs[17] = row(4,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[18] = row(2,   1, 0, 0, 1, 0, 0, 1, 3, 0, 1);
    vecs[19] = row(2,   1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[20] = row(3,   1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[21] = row(1,   1, 1, 2, 1, 1, 0, 1, 2, 1, 1);
    vecs[22] = row(4,   1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    vecs[23] = row(4,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[24] = row(1,   1, 0, 0, 1, 0, 0, 1, 3, 0, 1);
    vecs[25] = row(3,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[26] = row(1,   1, 1, 0, 1, 0, 0, 1, 3, 1, 1);
    vecs[27] = row(3,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[28] = row(1,   1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[29] = row(1,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[30] = row(1,   1, 1, 3, 0, 0, 1, 1, 0, 1, 1);
    vecs[31] = row(1,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[32] = row(1,   0, 0, 0, 1, 0, 0, 1, 3, 0, 1);
    vecs[33] = row(2,   0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[34] = row(1,   0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[35] = row(2,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[36] = row(5,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[37] = row(1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[38] = row(2,   1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[39] = row(1,   1, 0, 0, 1, 1, 0, 1, 2, 0, 1);
    vecs[40] = row(1,   1, 1, 9, 1, 0, 0, 1, 3, 1, 1);

    rst = 1'b1;
    en  = 1'b1;
    tick();
    tick();
    check("reset_state", obs(), 8'b0000_0001);
    rst = 1'b0;

    for (int i = 0; i < 41; i++) begin
      en       = vecs[i].en;
      div_load = vecs[i].dl;
      div_in   = vecs[i].din;
      tick();
      div_load = 1'b0;
      for (int k = 1; k < vecs[i].n; k++) tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Reset in the high half with a divisor pending: defaults come back.
    rst = 1'b1;
    tick();
    check("rst_mid_high", obs(), 8'b0000_0001);
    rst = 1'b0;
    begin
      int cnt;
      bit found;
      cnt   = 0;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
        tick();
        cnt++;
        if (rise) found = 1'b1;
      end
      check("rst_first_rise_cycles", cnt, 500);
    end
    check("rst_rise_state", obs(), 8'b1101_1001);
    repeat (500) tick();
    check("rst_fall_after_500", obs(), 8'b0011_0001);

    // Reset with en low: running drops the cycle after release.
    en  = 1'b0;
    rst = 1'b1;
    tick();
    check("boot_rst_run", obs(), 8'b0000_0001);
    rst = 1'b0;
    tick();
    check("boot_stop", obs(), 8'b0000_0000);
    repeat (3) tick();
    check("boot_idle", obs(), 8'b0000_0000);
    en = 1'b1;
    tick();
    check("boot_start", obs(), 8'b0000_0001);
    repeat (499) tick();
    check("boot_pre_rise", obs(), 8'b0000_0101);
    tick();
    check("boot_first_rise", obs(), 8'b1101_1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
